// File: rtl/shift_word_feeder.sv
// Buffers parallel words and feeds them to a left shift register: one load strobe, then WIDTH
// shift-enable pulses every DIV cycles. Define SHIFT_FEEDER_FIFO_EN for a DEPTH-entry FIFO.
module shift_word_feeder #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DIV   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       sr_load,
  output logic [WIDTH-1:0]           sr_data,
  output logic                       sr_en,
  output logic                       busy,
  output logic                       word_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [CntW-1:0]  count_q;
  logic [WIDTH-1:0] head;
  logic             full, push, pop, en_d;

  assign in_ready   = !full && !rst;
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;

`ifdef SHIFT_FEEDER_FIFO_EN
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;

  assign full = (count_q == CntW'(DEPTH));
  assign head = mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end
`else
  logic [WIDTH-1:0] hold_q;

  assign full = (count_q != '0);
  assign head = hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else if (push) begin
      hold_q <= in_data;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (push && !pop) begin
      count_q <= count_q + 1'b1;
    end else if (pop && !push) begin
      count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d = StLoad;
          pop     = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      StLoad: begin
        state_d = StShift;
        div_d   = '0;
        bit_d   = '0;
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = '0;
          if (bit_q == BitLast) begin
            // Chain straight into the next word so the stream has no idle gap.
            if (count_q != '0) begin
              state_d = StLoad;
              pop     = 1'b1;
              bit_d   = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  assign en_d = (state_d == StShift) && (div_d == DivLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      sr_load   <= 1'b0;
      sr_en     <= 1'b0;
      sr_data   <= '0;
      busy      <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sr_load   <= (state_d == StLoad);
      sr_en     <= en_d;
      busy      <= (state_d != StIdle);
      word_done <= en_d && (bit_d == BitLast);
      if (pop) begin
        sr_data <= head;
      end
    end
  end

endmodule

// File: tb/tb_shift_word_feeder.sv
// Bench for shift_word_feeder: two instances (DIV=1, DIV=3) checked every cycle against a
// timeline model, plus directed scenarios with literal expectations.
module tb_shift_word_feeder;

  localparam int W = 6;
`ifdef SHIFT_FEEDER_FIFO_EN
  localparam int Cap = 4;
`else
  localparam int Cap = 1;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   i_valid;
  logic [W-1:0] i_data [2];
  logic [1:0]   o_ready, o_load, o_en, o_busy, o_done;
  logic [W-1:0] o_data [2];
  logic [2:0]   o_cnt [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  shift_word_feeder #(.WIDTH(W), .DEPTH(4), .DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .in_valid(i_valid[0]), .in_ready(o_ready[0]), .in_data(i_data[0]),
    .sr_load(o_load[0]), .sr_data(o_data[0]), .sr_en(o_en[0]), .busy(o_busy[0]),
    .word_done(o_done[0]), .fifo_count(o_cnt[0])
  );

  shift_word_feeder #(.WIDTH(W), .DEPTH(4), .DIV(3)) u_div3 (
    .clk(clk), .rst(rst), .in_valid(i_valid[1]), .in_ready(o_ready[1]), .in_data(i_data[1]),
    .sr_load(o_load[1]), .sr_data(o_data[1]), .sr_en(o_en[1]), .busy(o_busy[1]),
    .word_done(o_done[1]), .fifo_count(o_cnt[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input int inst, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (inst %0d, cycle %0d): got %0h, expected %0h", name, inst, cyc, act, exp);
    end
  endtask

  // Model: a queue of words plus the load cycle of the word in flight; every output follows
  // from the distance between the current cycle and that load cycle.
  int           mdiv [2] = '{1, 3};
  logic [W-1:0] mbuf [2][8];
  int           mhd [2] = '{0, 0};
  int           mcnt [2] = '{0, 0};
  int           mld [2] = '{0, 0};
  bit           mfly [2] = '{1'b0, 1'b0};
  logic [W-1:0] mlast [2] = '{default: '0};

  int           a_ld[$], a_en[$], a_dn[$], b_ld[$], b_en[$], b_dn[$];
  logic [W-1:0] a_ldat[$];
  int           a_busy_n, a_ovl, a_max;

  initial begin
    int d, span;
    bit e_load, e_en, e_done, e_busy, e_ready, free;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        d       = cyc - mld[i];
        span    = W * mdiv[i];
        e_load  = mfly[i] && d == 0;
        e_en    = mfly[i] && d > 0 && d <= span && (d % mdiv[i]) == 0;
        e_done  = mfly[i] && d == span;
        e_busy  = mfly[i] && d <= span;
        e_ready = !rst && mcnt[i] < Cap;
        check("in_ready", i, o_ready[i], e_ready);
        check("sr_load", i, o_load[i], e_load);
        check("sr_en", i, o_en[i], e_en);
        check("word_done", i, o_done[i], e_done);
        check("busy", i, o_busy[i], e_busy);
        check("sr_data", i, o_data[i], mlast[i]);
        check("fifo_count", i, o_cnt[i], mcnt[i]);
        if (rst) begin
          mfly[i]  = 1'b0;
          mcnt[i]  = 0;
          mhd[i]   = 0;
          mlast[i] = '0;
        end else begin
          free = !mfly[i] || d == span;
          if (free && mcnt[i] != 0) begin
            mlast[i] = mbuf[i][mhd[i]];
            mhd[i]   = (mhd[i] + 1) % 8;
            mcnt[i]--;
            mfly[i]  = 1'b1;
            mld[i]   = cyc + 1;
          end else if (free) begin
            mfly[i] = 1'b0;
          end
          if (i_valid[i] && e_ready) begin
            mbuf[i][(mhd[i] + mcnt[i]) % 8] = i_data[i];
            mcnt[i]++;
          end
        end
      end
      if (o_load[0]) begin
        a_ld.push_back(cyc);
        a_ldat.push_back(o_data[0]);
      end
      if (o_en[0]) a_en.push_back(cyc);
      if (o_done[0]) a_dn.push_back(cyc);
      if (o_busy[0]) a_busy_n++;
      if (o_load[0] && o_en[0]) a_ovl++;
      if (int'(o_cnt[0]) > a_max) a_max = int'(o_cnt[0]);
      if (o_load[1]) b_ld.push_back(cyc);
      if (o_en[1]) b_en.push_back(cyc);
      if (o_done[1]) b_dn.push_back(cyc);
    end
  end

  task automatic clear_logs();
    a_ld.delete(); a_ldat.delete(); a_en.delete(); a_dn.delete();
    b_ld.delete(); b_en.delete(); b_dn.delete();
    a_busy_n = 0; a_ovl = 0; a_max = 0;
  endtask

  task automatic send(input int i, input logic [W-1:0] d, output int t_acc);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    t_acc = 0;
    i_valid[i] = 1'b1;
    i_data[i] = d;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = o_ready[i];
      t_acc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid[i] = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout (inst %0d): in_ready got 0, expected 1 within 200 cycles", i);
    end
  endtask

  task automatic wait_idle(input int i);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < 400) begin
      @(negedge clk);
      idle = !o_busy[i] && o_cnt[i] == 0;
      n++;
    end
    @(posedge clk);
    #1;
    if (!idle) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout (inst %0d): busy got 1, expected 0 within 400 cycles", i);
    end
  endtask

  initial begin
    int t0, t, n, en_before, dn_before;
    rst = 1'b1;
    i_valid = '0;
    i_data[0] = '0;
    i_data[1] = '0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single word, DIV=1
    clear_logs();
    send(0, 6'b101101, t0);
    wait_idle(0);
    check("single_nloads", 0, a_ld.size(), 1);
    if (a_ld.size() >= 1) begin
      check("single_load_cyc", 0, a_ld[0] - t0, 2);
      check("single_load_data", 0, a_ldat[0], 6'h2D);
    end
    check("single_nen", 0, a_en.size(), 6);
    if (a_en.size() == 6) begin
      check("single_first_en", 0, a_en[0] - t0, 3);
      check("single_last_en", 0, a_en[5] - t0, 8);
    end
    check("single_ndone", 0, a_dn.size(), 1);
    if (a_dn.size() >= 1) check("single_done_cyc", 0, a_dn[0] - t0, 8);
    check("single_busy_cycles", 0, a_busy_n, 7);

    // Back-to-back, DIV=1
    clear_logs();
    send(0, 6'h01, t0);
    for (int k = 2; k <= 5; k++) send(0, 6'(k), t);
    wait_idle(0);
    check("b2b_nloads", 0, a_ld.size(), 5);
    if (a_ld.size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        check("b2b_load_cyc", 0, a_ld[k] - t0, 2 + 7 * k);
        check("b2b_load_data", 0, a_ldat[k], 6'(k + 1));
      end
    end
    check("b2b_nen", 0, a_en.size(), 30);
    check("b2b_overlap", 0, a_ovl, 0);
    check("b2b_max_count", 0, a_max, Cap);

    // DIV=3
    clear_logs();
    send(1, 6'h3F, t0);
    wait_idle(1);
    check("div3_nloads", 1, b_ld.size(), 1);
    check("div3_nen", 1, b_en.size(), 6);
    if (b_ld.size() == 1 && b_en.size() == 6) begin
      for (int k = 0; k < 6; k++) check("div3_en_offset", 1, b_en[k] - b_ld[0], 3 * (k + 1));
    end
    check("div3_ndone", 1, b_dn.size(), 1);
    if (b_ld.size() == 1 && b_dn.size() == 1) check("div3_done_offset", 1, b_dn[0] - b_ld[0], 18);

    // Reset mid-shift with words still buffered
    clear_logs();
    send(0, 6'h11, t0);
    send(0, 6'h22, t);
    if (Cap > 1) send(0, 6'h33, t);
    n = 0;
    while (a_en.size() < 3 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rst_third_en_seen", 0, a_en.size() >= 3, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    en_before = a_en.size();
    dn_before = a_dn.size();
    @(negedge clk);
    check("rst_after_count", 0, o_cnt[0], 0);
    check("rst_after_data", 0, o_data[0], 0);
    check("rst_after_ready", 0, o_ready[0], 1);
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_more_en", 0, a_en.size(), en_before);
    check("rst_no_more_done", 0, a_dn.size(), dn_before);
    check("rst_total_en", 0, a_en.size(), 4);
    check("rst_no_done", 0, a_dn.size(), 0);

    // Pointer wrap: ten words with gaps
    clear_logs();
    for (int k = 0; k < 10; k++) begin
      send(0, 6'(16 + k), t);
      repeat (k % 3) begin
        @(posedge clk);
        #1;
      end
    end
    wait_idle(0);
    check("wrap_nloads", 0, a_ld.size(), 10);
    if (a_ld.size() == 10) begin
      for (int k = 0; k < 10; k++) check("wrap_order", 0, a_ldat[k], 6'(16 + k));
    end
    check("wrap_count_bound", 0, a_max <= Cap, 1);
    check("wrap_overlap", 0, a_ovl, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_word_feeder.md
# shift_word_feeder

Upstream feeder for the 6-bit left shift register. It accepts parallel words over a valid/ready handshake and buffers them. For each word it drives the register's load strobe with the word, then issues exactly WIDTH shift-enable pulses at a programmable rate. Words are streamed back-to-back with no idle cycles when the buffer is non-empty.

## Interface
- WIDTH, 6: word width; must match the downstream shift register.
- DEPTH, 4: buffer entries when the FIFO is compiled in; power of 2, ≥2.
- DIV, 1: clock cycles per shift step; ≥1.

- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  upstream word available.
- in_ready  out  1  buffer can accept; equals !full, forced 0 while rst=1.
- in_data  in  WIDTH  word to serialise.
- sr_load  out  1  one-cycle load strobe; connects to the shift register's rst/load input.
- sr_data  out  WIDTH  word presented to the shift register's load input.
- sr_en  out  1  one-cycle shift-enable pulse.
- busy  out  1  high from the sr_load cycle through the last sr_en cycle of a word.
- word_done  out  1  one-cycle pulse, coincident with the WIDTH-th sr_en.
- fifo_count  out  $clog2(DEPTH+1)  number of buffered words, not counting the word in flight.

## Operation
- Push: in_valid && in_ready at a rising edge writes in_data at the tail and increments fifo_count.
- Pop: happens at a rising edge when the FSM starts a word. It removes the head and decrements fifo_count.
- A push and a pop on the same edge leave fifo_count unchanged.
- There is no pass-through: a word pushed into an empty buffer is popped no earlier than the next edge.
- FSM states:
  - IDLE → LOAD when fifo_count≠0 (pop).
  - LOAD lasts one cycle: sr_load=1, sr_data=popped word, div_cnt=0, bit_cnt=0. Then → SHIFT.
  - SHIFT: div_cnt counts 0..DIV-1. When div_cnt=DIV-1, sr_en=1 for that cycle and bit_cnt increments.
  - On the cycle with bit_cnt=WIDTH-1 and sr_en=1, word_done=1. The next state is LOAD (pop) if fifo_count≠0, else IDLE.
- sr_load and sr_en are never high in the same cycle. The shift register gives load priority, so overlap would lose a shift.
- sr_data holds the last loaded word until the next load. It does not change during SHIFT.
- All outputs except in_ready are registered.
- Reset values: sr_load=0, sr_en=0, sr_data=0, busy=0, word_done=0, fifo_count=0, state=IDLE, in_ready=0 during rst.
- Reset mid-operation: the word in flight is aborted with no further sr_en and no word_done, and the buffer is flushed. in_ready=1 in the first cycle after rst deasserts.

## Timing
- Word accepted at the edge ending cycle c, block idle and empty: sr_load is high in cycle c+2.
- Load in cycle L: sr_en is high in cycles L+k·DIV for k=1..WIDTH. word_done is high in L+WIDTH·DIV.
- Next load is in cycle L+WIDTH·DIV+1 if a word is buffered. The steady-state period is 1+WIDTH·DIV cycles per word.
- in_ready falls in the cycle after the push that makes fifo_count=DEPTH. It rises in the cycle after the next pop.

## Configuration
- SHIFT_FEEDER_FIFO_EN defined: the buffer is a DEPTH-entry circular FIFO with wrap-around read and write pointers. fifo_count ranges 0..DEPTH.
- SHIFT_FEEDER_FIFO_EN undefined: the buffer is a single holding register and DEPTH is ignored. fifo_count ranges 0..1, and in_ready=0 while the holding register is occupied. Timing is otherwise identical.

## Test plan
- Single word, DIV=1: push 6'b101101 in cycle 0 → sr_load=1 and sr_data=6'h2D in cycle 2. sr_en in cycles 3..8, word_done in cycle 8, busy in cycles 2..8, idle from cycle 9.
- Back-to-back, DIV=1, FIFO on: push 6'h01,6'h02,6'h03,6'h04,6'h05 on consecutive cycles.
  - in_ready drops once fifo_count=4.
  - Loads in cycles 2, 9, 16, 23, 30 with words in push order.
  - Exactly 30 sr_en pulses in total.
  - sr_load and sr_en never overlap.
- DIV=3: push 6'h3F → load in cycle L, sr_en in cycles L+3, L+6, …, L+18, word_done in L+18.
- Reset mid-shift: assert rst for one cycle after the 3rd sr_en with 2 words buffered.
  - No further sr_en or word_done.
  - fifo_count=0 and sr_data=0 after reset.
  - in_ready=1 in the next cycle.
- FIFO off: push two words on consecutive cycles → the second push stalls (in_ready=0) until the first word is popped. The words are loaded in order 7 cycles apart at DIV=1.
- Pointer wrap, FIFO on: stream 10 words with intermittent in_valid gaps → all 10 are loaded in order, and fifo_count never exceeds 4.
